// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with two registered read ports, one write port
// and a per-register busy scoreboard.  A producer reserves a destination with
// rsv/rsv_addr (sets its busy bit).  The write that later delivers the data
// (load/c_addr) clears that bit again.  Register 0 can optionally be tied to
// constant zero.  Same-cycle write-to-read forwarding is selectable.
//
// Parameters
//   DATA_W   register / data width (1..64)
//   ADDR_W   address width, DEPTH = 2**ADDR_W registers (1..6)
//   ZERO_R0  1: register 0 reads as zero, ignores writes/reserves, never busy
//   BYPASS   1: a write in the same cycle as a read of that address is
//               forwarded to the read output; 0: the old value is returned
//
// Ports
//   clk                rising-edge clock
//   clear              synchronous active-high reset, wins over load/rsv
//   a_addr, b_addr     read addresses, sampled on the edge
//   a_out, b_out       registered read data (1 cycle latency)
//   a_busy, b_busy     registered busy flag of a_addr/b_addr (post-update)
//   c_addr, c_data     write address / data
//   load               write enable; also releases busy[c_addr]
//   rsv, rsv_addr      reserve strobe / address; sets busy[rsv_addr]
//   m_state            debug register select
//   m_data             combinational {r[m_state], r[m_state+1 wrapped]}
// ---------------------------------------------------------------------------
module reg_file_param #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 4,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                clk,
    input  logic                clear,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [ADDR_W-1:0]   b_addr,
    output logic [DATA_W-1:0]   a_out,
    output logic [DATA_W-1:0]   b_out,
    output logic                a_busy,
    output logic                b_busy,
    input  logic [ADDR_W-1:0]   c_addr,
    input  logic [DATA_W-1:0]   c_data,
    input  logic                load,
    input  logic                rsv,
    input  logic [ADDR_W-1:0]   rsv_addr,
    input  logic [ADDR_W-1:0]   m_state,
    output logic [2*DATA_W-1:0] m_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    // -----------------------------------------------------------------------
    // Storage.  Two independent read ports plus the two-entry debug view need
    // simultaneous random access, so the file lives in flops.
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [DATA_W-1:0] a_out_q, a_out_d;
    logic [DATA_W-1:0] b_out_q, b_out_d;
    logic              a_busy_q, a_busy_d;
    logic              b_busy_q, b_busy_d;

    // -----------------------------------------------------------------------
    // Effective write / reserve strobes.  With a hard-wired zero register the
    // address-0 requests are dropped here, so nothing downstream (storage,
    // scoreboard or forwarding path) ever sees them.
    // -----------------------------------------------------------------------
    logic wr_en;
    logic rsv_en;
    logic c_is_r0;
    logic rsv_is_r0;

    assign c_is_r0   = (c_addr == '0);
    assign rsv_is_r0 = (rsv_addr == '0);
    assign wr_en     = load & ~(ZERO_R0 & c_is_r0);
    assign rsv_en    = rsv & ~(ZERO_R0 & rsv_is_r0);

    // -----------------------------------------------------------------------
    // Per-register next state
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

            if (ZERO_R0 && (gi == 0)) begin : g_zero
                assign regs_d[gi] = '0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_norm
                logic wr_hit;
                logic rsv_hit;

                assign wr_hit     = wr_en & (c_addr == IDX);
                assign rsv_hit    = rsv_en & (rsv_addr == IDX);
                assign regs_d[gi] = wr_hit ? c_data : regs_q[gi];
                // A reserve and a release on the same register in one cycle
                // leave it busy: the new producer is still outstanding.
                assign busy_d[gi] = rsv_hit | (busy_q[gi] & ~wr_hit);
            end

            always_ff @(posedge clk) begin
                if (clear) begin
                    regs_q[gi] <= '0;
                    busy_q[gi] <= 1'b0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                    busy_q[gi] <= busy_d[gi];
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Read ports.  Data either comes from the stored value or, when enabled,
    // from the write in flight.  Busy always reflects the post-update
    // scoreboard regardless of forwarding, so a reserve issued this cycle is
    // already visible on the flag next cycle.
    // -----------------------------------------------------------------------
    logic a_fwd;
    logic b_fwd;

    assign a_fwd = BYPASS & wr_en & (c_addr == a_addr);
    assign b_fwd = BYPASS & wr_en & (c_addr == b_addr);

    always_comb begin
        a_out_d  = regs_q[a_addr];
        b_out_d  = regs_q[b_addr];
        if (a_fwd) begin
            a_out_d = c_data;
        end
        if (b_fwd) begin
            b_out_d = c_data;
        end
        // Redundant with regs_q[0] being held at zero, but keeps the zero
        // register exact even if storage is ever retimed or initialised.
        if (ZERO_R0 && (a_addr == '0)) begin
            a_out_d = '0;
        end
        if (ZERO_R0 && (b_addr == '0)) begin
            b_out_d = '0;
        end
        a_busy_d = busy_d[a_addr];
        b_busy_d = busy_d[b_addr];
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            a_out_q  <= '0;
            b_out_q  <= '0;
            a_busy_q <= 1'b0;
            b_busy_q <= 1'b0;
        end else begin
            a_out_q  <= a_out_d;
            b_out_q  <= b_out_d;
            a_busy_q <= a_busy_d;
            b_busy_q <= b_busy_d;
        end
    end

    assign a_out  = a_out_q;
    assign b_out  = b_out_q;
    assign a_busy = a_busy_q;
    assign b_busy = b_busy_q;

    // -----------------------------------------------------------------------
    // Debug view: straight from storage, no forwarding.  The successor index
    // wraps naturally through ADDR_W-bit arithmetic.
    // -----------------------------------------------------------------------
    logic [ADDR_W-1:0] m_next;
    logic [DATA_W-1:0] m_hi;
    logic [DATA_W-1:0] m_lo;

    assign m_next = m_state + ADDR_W'(1);

    always_comb begin
        m_hi = regs_q[m_state];
        m_lo = regs_q[m_next];
        if (ZERO_R0 && (m_state == '0)) begin
            m_hi = '0;
        end
        if (ZERO_R0 && (m_next == '0)) begin
            m_lo = '0;
        end
    end

    assign m_data = {m_hi, m_lo};

endmodule

// File: tb/tb_reg_file_param.sv
// ---------------------------------------------------------------------------
// tb_reg_file_param
//
// Three instances share one stimulus stream:
//   dut 0: ZERO_R0=0 BYPASS=1   dut 1: ZERO_R0=1 BYPASS=0   dut 2: ZERO_R0=1 BYPASS=1
// A behavioural model predicts each instance's outputs after every edge and
// queues them; an independent monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_reg_file_param;

    localparam int NI = 3;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        ab;
        logic        bb;
        logic [31:0] m;
    } exp_t;

    typedef struct packed {
        exp_t [NI-1:0] e;
    } bundle_t;

    logic        clk;
    logic        clear;
    logic        load;
    logic        rsv;
    logic [3:0]  a_addr;
    logic [3:0]  b_addr;
    logic [3:0]  c_addr;
    logic [3:0]  rsv_addr;
    logic [3:0]  m_state;
    logic [15:0] c_data;

    logic [15:0] ao [NI];
    logic [15:0] bo [NI];
    logic        abz [NI];
    logic        bbz [NI];
    logic [31:0] md [NI];

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut0 (
        .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
        .a_out(ao[0]), .b_out(bo[0]), .a_busy(abz[0]), .b_busy(bbz[0]),
        .c_addr(c_addr), .c_data(c_data), .load(load), .rsv(rsv),
        .rsv_addr(rsv_addr), .m_state(m_state), .m_data(md[0])
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut1 (
        .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
        .a_out(ao[1]), .b_out(bo[1]), .a_busy(abz[1]), .b_busy(bbz[1]),
        .c_addr(c_addr), .c_data(c_data), .load(load), .rsv(rsv),
        .rsv_addr(rsv_addr), .m_state(m_state), .m_data(md[1])
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut2 (
        .clk(clk), .clear(clear), .a_addr(a_addr), .b_addr(b_addr),
        .a_out(ao[2]), .b_out(bo[2]), .a_busy(abz[2]), .b_busy(bbz[2]),
        .c_addr(c_addr), .c_data(c_data), .load(load), .rsv(rsv),
        .rsv_addr(rsv_addr), .m_state(m_state), .m_data(md[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    bit          cfg_zero [NI] = '{1'b0, 1'b1, 1'b1};
    bit          cfg_byp  [NI] = '{1'b1, 1'b0, 1'b1};
    logic [15:0] mem  [NI][16];
    logic        busy [NI][16];

    bundle_t     q [$];
    int          total   = 0;
    int          bad     = 0;
    bit          running = 1'b0;

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%h required=%h", name, k, $time, act, req);
        end
    endtask

    // Predict the outputs the coming edge will produce, advance the model,
    // then let that edge happen (returns on the following falling edge).
    task automatic step();
        bundle_t    bd;
        logic [3:0] mn;
        bit         wr;
        bit         rv;
        mn = m_state + 4'd1;
        for (int k = 0; k < NI; k++) begin
            if (clear) begin
                for (int r = 0; r < 16; r++) begin
                    mem[k][r]  = 16'h0;
                    busy[k][r] = 1'b0;
                end
                bd.e[k].a = 16'h0;
                bd.e[k].b = 16'h0;
            end else begin
                wr = load && !(cfg_zero[k] && c_addr == 4'd0);
                rv = rsv && !(cfg_zero[k] && rsv_addr == 4'd0);
                bd.e[k].a = (cfg_byp[k] && wr && c_addr == a_addr) ? c_data : mem[k][a_addr];
                bd.e[k].b = (cfg_byp[k] && wr && c_addr == b_addr) ? c_data : mem[k][b_addr];
                if (wr) begin
                    mem[k][c_addr]  = c_data;
                    busy[k][c_addr] = 1'b0;
                end
                if (rv) begin
                    busy[k][rsv_addr] = 1'b1;
                end
            end
            bd.e[k].ab = busy[k][a_addr];
            bd.e[k].bb = busy[k][b_addr];
            bd.e[k].m  = {mem[k][m_state], mem[k][mn]};
        end
        q.push_back(bd);
        @(negedge clk);
    endtask

    task automatic quiet();
        clear = 1'b0;
        load  = 1'b0;
        rsv   = 1'b0;
    endtask

    task automatic wr_reg(input logic [3:0] addr, input logic [15:0] data);
        quiet();
        load   = 1'b1;
        c_addr = addr;
        c_data = data;
        step();
    endtask

    // Monitor: compare after every edge while stimulus is active
    initial begin
        bundle_t bd;
        forever begin
            @(posedge clk);
            #1;
            if (running) begin
                if (q.size() == 0) begin
                    chk("queue_empty", 0, 32'd0, 32'd1);
                end else begin
                    bd = q.pop_front();
                    for (int k = 0; k < NI; k++) begin
                        chk("a_out",  k, {16'h0, ao[k]},  {16'h0, bd.e[k].a});
                        chk("b_out",  k, {16'h0, bo[k]},  {16'h0, bd.e[k].b});
                        chk("a_busy", k, {31'h0, abz[k]}, {31'h0, bd.e[k].ab});
                        chk("b_busy", k, {31'h0, bbz[k]}, {31'h0, bd.e[k].bb});
                        chk("m_data", k, md[k], bd.e[k].m);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        clear = 1'b1; load = 1'b0; rsv = 1'b0;
        a_addr = 4'd0; b_addr = 4'd0; c_addr = 4'd0; rsv_addr = 4'd0;
        m_state = 4'd0; c_data = 16'h0;
        running = 1'b1;

        // Reset
        step();
        step();

        // Write then read
        wr_reg(4'd5, 16'h1234);
        quiet(); a_addr = 4'd5; b_addr = 4'd5; m_state = 4'd4;
        step();

        // Forwarding vs pre-write value
        wr_reg(4'd3, 16'h0001);
        quiet(); load = 1'b1; c_addr = 4'd3; c_data = 16'hBEEF; a_addr = 4'd3; b_addr = 4'd5;
        step();

        // Scoreboard: reserve, release, reserve+release together
        quiet(); rsv = 1'b1; rsv_addr = 4'd7; a_addr = 4'd7; b_addr = 4'd3;
        step();
        wr_reg(4'd7, 16'h7777);
        quiet(); rsv = 1'b1; rsv_addr = 4'd7; load = 1'b1; c_addr = 4'd7; c_data = 16'h1357;
        step();
        quiet(); m_state = 4'd6;
        step();

        // Clear wins over a simultaneous write
        wr_reg(4'd2, 16'h2222);
        wr_reg(4'd4, 16'h4444);
        quiet(); rsv = 1'b1; rsv_addr = 4'd2; a_addr = 4'd2; b_addr = 4'd4;
        step();
        quiet(); clear = 1'b1; load = 1'b1; c_addr = 4'd4; c_data = 16'hFFFF;
        rsv = 1'b1; rsv_addr = 4'd9;
        step();
        for (int i = 0; i < 16; i++) begin
            quiet(); m_state = 4'(i); a_addr = 4'(i); b_addr = 4'd2;
            step();
        end

        // Register 0 writes/reserves, including same-cycle read
        quiet(); load = 1'b1; c_addr = 4'd0; c_data = 16'hAAAA;
        rsv = 1'b1; rsv_addr = 4'd0; a_addr = 4'd0; b_addr = 4'd0; m_state = 4'd0;
        step();
        quiet();
        step();

        // Debug wrap
        wr_reg(4'd15, 16'h00F0);
        wr_reg(4'd0, 16'h0F00);
        quiet(); m_state = 4'd15;
        step();

        // Randomised traffic; a narrow address window at times forces collisions
        for (int n = 0; n < 600; n++) begin
            bit narrow;
            narrow   = ($urandom_range(0, 3) == 0);
            clear    = ($urandom_range(0, 63) == 0);
            load     = $urandom_range(0, 1) != 0;
            rsv      = ($urandom_range(0, 2) == 0);
            a_addr   = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            b_addr   = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            c_addr   = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            rsv_addr = narrow ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
            m_state  = 4'($urandom_range(0, 15));
            c_data   = 16'($urandom);
            step();
        end

        quiet();
        running = 1'b0;
        @(posedge clk);
        #2;
        chk("queue_drained", 0, 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
REG_FILE_PARAM -- requirements
Module: reg_file_param

Interface
Parameters:
REQ-001 DATA_W, default 16: register and data port width in bits; legal range 1..64.
REQ-002 ADDR_W, default 4: address width; register count DEPTH = 2**ADDR_W; legal range 1..6.
REQ-003 ZERO_R0, default 0: 1 = register 0 reads as constant zero, ignores writes and is never busy.
REQ-004 BYPASS, default 1: 1 = same-cycle write data is forwarded to the read outputs; 0 = the read outputs show the pre-write value.
Ports:
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 clear  in  1  reset; synchronous, active-high.
REQ-007 a_addr  in  ADDR_W  read port A address.
REQ-008 b_addr  in  ADDR_W  read port B address.
REQ-009 a_out  out  DATA_W  registered read data for port A.
REQ-010 b_out  out  DATA_W  registered read data for port B.
REQ-011 a_busy  out  1  registered scoreboard busy flag for a_addr.
REQ-012 b_busy  out  1  registered scoreboard busy flag for b_addr.
REQ-013 c_addr  in  ADDR_W  write address.
REQ-014 c_data  in  DATA_W  write data.
REQ-015 load  in  1  write enable.
REQ-016 rsv  in  1  reserve strobe; marks rsv_addr busy (pending producer).
REQ-017 rsv_addr  in  ADDR_W  reserve address.
REQ-018 m_state  in  ADDR_W  debug register select.
REQ-019 m_data  out  2*DATA_W  combinational debug view {r[m_state], r[(m_state+1) mod DEPTH]}.

Function
REQ-020 Storage: DEPTH registers of DATA_W bits, plus one busy bit per register.
REQ-021 Write: when load=1 at an edge, r[c_addr] <= c_data; no other register changes.
REQ-022 Read latency: exactly 1 cycle; the edge that samples a_addr/b_addr updates a_out/b_out.
REQ-023 BYPASS=1: if load=1 and c_addr==a_addr at the sampling edge, a_out <= c_data; port B likewise.
REQ-024 BYPASS=0: under the same condition, a_out/b_out <= the value held before that edge.
REQ-025 Both read ports on the same address return identical data.
REQ-026 Reserve: when rsv=1 at an edge, busy[rsv_addr] <= 1.
REQ-027 Release: when load=1 at an edge, busy[c_addr] <= 0, unless REQ-028 applies.
REQ-028 Simultaneous rsv and load to the same address: busy ends at 1 (reserve wins); the data write still occurs.
REQ-029 Busy flags: a_busy/b_busy <= the busy bit of a_addr/b_addr after the current edge's update (post-update value), independent of BYPASS.
REQ-030 ZERO_R0=1, writes: load with c_addr=0 is ignored.
REQ-031 ZERO_R0=1, reserve: rsv with rsv_addr=0 is ignored.
REQ-032 ZERO_R0=1, reads and debug: register 0 reads 0 and shows not-busy on all ports, including m_data and the bypass path.
REQ-033 Debug wrap: m_state=DEPTH-1 yields {r[DEPTH-1], r[0]}.
REQ-034 m_data reflects register contents only; it has no bypass and no latency beyond the register update.
REQ-035 Out-of-range addresses cannot occur; every ADDR_W value is a valid register.

Reset
REQ-036 clear=1 at an edge sets all registers to 0, all busy bits to 0, a_out=b_out=0 and a_busy=b_busy=0.
REQ-037 clear has priority over load and rsv in the same cycle; a write or reserve presented with clear is discarded.
REQ-038 The first edge after clear deasserts performs normal reads, writes and reserves.
REQ-039 Before the first clear, all state is undefined; the bench applies clear at least 1 cycle first.

Verification (DATA_W=16, ADDR_W=4 unless stated)
REQ-040 Write/read: load r5=0x1234; next cycle a_addr=5, b_addr=5 -> one edge later a_out=b_out=0x1234.
REQ-041 Bypass: r3=0x0001, then load c_addr=3, c_data=0xBEEF with a_addr=3 in the same cycle -> a_out=0xBEEF with BYPASS=1, a_out=0x0001 with BYPASS=0.
REQ-042 Scoreboard:
- rsv r7 -> a_busy=1 for a_addr=7 after the edge.
- load r7 -> a_busy=0.
- rsv and load on r7 in the same cycle -> a_busy=1 and r7 holds the new data.
REQ-043 Clear priority: registers loaded, r2 reserved; then clear=1 together with load r4=0xFFFF -> all outputs 0, r4=0, busy[2]=0, m_data=0 for every m_state.
REQ-044 ZERO_R0=1: load r0=0xAAAA and rsv r0 -> a_addr=0 gives a_out=0, a_busy=0, including the same-cycle bypass case.
REQ-045 Debug wrap: r15=0x00F0, r0=0x0F00 (ZERO_R0=0), m_state=15 -> m_data=0x00F00F00.
